// File: rtl/ddr_crc5_engine.sv
// HDR-DDR CRC-5 (x^5+x^2+1) over strobed data bytes, MSB first; optional compare against the received CRC.
// Latency: byte at T folds by T+DATA_W, valid in T+DATA_W+1; strobes while busy are dropped and flag overrun.
module ddr_crc5_engine #(
   parameter logic [4:0] CRC_SEED = 5'h1F,
   parameter logic [4:0] CRC_POLY = 5'h05,
   parameter int         DATA_W   = 8
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst_n,
   input  logic              i_txrx_crc_init,
   input  logic              i_txrx_crc_en,
   input  logic [DATA_W-1:0] i_txrx_parallel_data,
   input  logic              i_txrx_last_byte,
   input  logic              i_rx_crc_check,
   input  logic [4:0]        i_rx_crc_received,
   output logic              o_crc_busy,
   output logic [4:0]        o_crc_value,
   output logic              o_crc_valid,
   output logic              o_crc_match,
   output logic              o_crc_error,
   output logic              o_crc_overrun
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   logic [4:0]        r_crc;
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_last;
   logic              r_overrun;

   logic              w_fb;
   logic [4:0]        w_crc_next;

   assign w_fb       = r_crc[4] ^ r_shift[DATA_W-1];
   assign w_crc_next = {r_crc[3:0], 1'b0} ^ (w_fb ? CRC_POLY : 5'h00);

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_state   <= S_IDLE;
         r_crc     <= CRC_SEED;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_last    <= 1'b0;
         r_overrun <= 1'b0;
      end else if (i_txrx_crc_init) begin
         // Reseed wins, but a same-cycle strobe is still taken against the fresh seed.
         r_crc     <= CRC_SEED;
         r_overrun <= 1'b0;
         if (i_txrx_crc_en) begin
            r_shift <= i_txrx_parallel_data;
            r_last  <= i_txrx_last_byte;
            r_cnt   <= CNT_LAST;
            r_state <= S_SHIFT;
         end else begin
            r_state <= S_IDLE;
         end
      end else begin
         case (r_state)
            S_SHIFT: begin
               r_crc   <= w_crc_next;
               r_shift <= r_shift << 1;
               r_cnt   <= r_cnt - CNT_W'(1);
               if (i_txrx_crc_en) begin
                  r_overrun <= 1'b1;
               end
               if (r_cnt == '0) begin
                  r_state <= r_last ? S_DONE : S_IDLE;
               end
            end
            default: begin
               if (i_txrx_crc_en) begin
                  r_shift <= i_txrx_parallel_data;
                  r_last  <= i_txrx_last_byte;
                  r_cnt   <= CNT_LAST;
                  r_state <= S_SHIFT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign o_crc_busy    = (r_state == S_SHIFT);
   assign o_crc_valid   = (r_state == S_DONE);
   assign o_crc_value   = r_crc;
   assign o_crc_overrun = r_overrun;
   // The received CRC is sampled live in the DONE cycle.
   assign o_crc_match   = o_crc_valid & i_rx_crc_check & (r_crc == i_rx_crc_received);
   assign o_crc_error   = o_crc_valid & i_rx_crc_check & (r_crc != i_rx_crc_received);

endmodule

// File: tb/tb_ddr_crc5_engine.sv
// Directed bench for ddr_crc5_engine with a scoreboard of expected final CRCs.
module tb_ddr_crc5_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       init, en, last, check;
   logic [7:0] data;
   logic [4:0] recv;
   logic       busy, valid, match, err, overrun;
   logic [4:0] value;

   always #5 clk = ~clk;

   ddr_crc5_engine dut (
      .i_sys_clk            (clk),
      .i_sys_rst_n          (rst_n),
      .i_txrx_crc_init      (init),
      .i_txrx_crc_en        (en),
      .i_txrx_parallel_data (data),
      .i_txrx_last_byte     (last),
      .i_rx_crc_check       (check),
      .i_rx_crc_received    (recv),
      .o_crc_busy           (busy),
      .o_crc_value          (value),
      .o_crc_valid          (valid),
      .o_crc_match          (match),
      .o_crc_error          (err),
      .o_crc_overrun        (overrun)
   );

   typedef struct packed {
      logic [4:0] crc;
      logic       match;
      logic       err;
   } exp_t;

   exp_t       sb_q[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   logic [4:0] m_crc  = 5'h1F;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
      logic       fb;
      logic [4:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[4] ^ d[i];
         r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      end
      return r;
   endfunction

   // Scoreboard consumer: every valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_valid", 8'd1, 8'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_value", {3'b0, value}, {3'b0, e.crc});
            chk("sb_match", {7'b0, match}, {7'b0, e.match});
            chk("sb_error", {7'b0, err}, {7'b0, e.err});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init();
      init = 1'b1;
      tick();
      init  = 1'b0;
      m_crc = 5'h1F;
   endtask

   task automatic strobe(input logic [7:0] b, input logic l);
      exp_t e;
      en   = 1'b1;
      data = b;
      last = l;
      tick();
      en    = 1'b0;
      last  = 1'b0;
      m_crc = crc5_byte(m_crc, b);
      if (l) begin
         e.crc   = m_crc;
         e.match = check & (m_crc == recv);
         e.err   = check & (m_crc != recv);
         sb_q.push_back(e);
      end
   endtask

   // Returns at the first negedge with busy low, having counted busy cycles.
   task automatic wait_idle(output int n);
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) chk("wait_idle_timeout", 8'd1, 8'd0);
   endtask

   initial begin
      int n, nv;
      logic [7:0] b;
      logic [4:0] f;
      rst_n = 1'b0; init = 1'b0; en = 1'b0; last = 1'b0;
      check = 1'b0; data = 8'h00; recv = 5'h00;
      tick(); tick();
      chk("rst_value", {3'b0, value}, 8'h1F);
      chk("rst_busy", {7'b0, busy}, 8'd0);
      chk("rst_valid", {7'b0, valid}, 8'd0);
      chk("rst_match", {7'b0, match}, 8'd0);
      chk("rst_error", {7'b0, err}, 8'd0);
      chk("rst_overrun", {7'b0, overrun}, 8'd0);
      rst_n = 1'b1;
      tick();

      // Single zero byte: 8 busy cycles then valid with 0x0F.
      do_init();
      strobe(8'h00, 1'b1);
      wait_idle(n);
      chk("busy_cycles", 8'(n), 8'd8);
      chk("valid_00", {7'b0, valid}, 8'd1);
      chk("value_00", {3'b0, value}, 8'h0F);
      #1;

      do_init();
      strobe(8'hFF, 1'b1);
      wait_idle(n);
      chk("value_ff", {3'b0, value}, 8'h1B);
      #1;

      // Two-byte chain: no valid after the non-last byte.
      do_init();
      strobe(8'h00, 1'b0);
      wait_idle(n);
      chk("no_valid_mid", {7'b0, valid}, 8'd0);
      chk("value_mid", {3'b0, value}, 8'h0F);
      #1;
      strobe(8'hFF, 1'b1);
      wait_idle(n);
      chk("value_00ff", {3'b0, value}, 8'h15);
      #1;
      tick();
      chk("value_held", {3'b0, value}, 8'h15);

      // Receive compare: match then error.
      check = 1'b1; recv = 5'h15;
      do_init();
      strobe(8'h00, 1'b0); wait_idle(n); #1;
      strobe(8'hFF, 1'b1); wait_idle(n);
      chk("match_pulse", {7'b0, match}, 8'd1);
      chk("match_noerr", {7'b0, err}, 8'd0);
      #1;
      recv = 5'h14;
      do_init();
      strobe(8'h00, 1'b0); wait_idle(n); #1;
      strobe(8'hFF, 1'b1); wait_idle(n);
      chk("error_pulse", {7'b0, err}, 8'd1);
      chk("error_nomatch", {7'b0, match}, 8'd0);
      #1;
      check = 1'b0;

      // Overrun: second strobe at T+3 is dropped.
      do_init();
      strobe(8'hFF, 1'b1);
      tick(); tick();
      en = 1'b1; data = 8'h00; last = 1'b1;
      tick();
      en = 1'b0; last = 1'b0;
      chk("overrun_set", {7'b0, overrun}, 8'd1);
      wait_idle(n);
      chk("overrun_value", {3'b0, value}, 8'h1B);
      chk("overrun_sticky", {7'b0, overrun}, 8'd1);
      #1;
      do_init();
      chk("overrun_clr", {7'b0, overrun}, 8'd0);
      chk("init_value", {3'b0, value}, 8'h1F);

      // Strobe during the DONE cycle is accepted back-to-back.
      strobe(8'hFF, 1'b1);
      repeat (8) tick();
      chk("done_cycle", {7'b0, valid}, 8'd1);
      strobe(8'h00, 1'b1);
      wait_idle(n);
      chk("b2b_busy", 8'(n), 8'd8);
      chk("b2b_value", {3'b0, value}, 8'h1E);
      #1;

      // init and en together mid-byte: fresh seed, byte accepted, no overrun.
      do_init();
      en = 1'b1; data = 8'hAA; last = 1'b1;
      tick();
      en = 1'b0; last = 1'b0;
      tick(); tick();
      init = 1'b1; en = 1'b1; data = 8'h00; last = 1'b1;
      tick();
      init = 1'b0; en = 1'b0; last = 1'b0;
      m_crc = 5'h1F;
      m_crc = crc5_byte(m_crc, 8'h00);
      sb_q.push_back('{crc: m_crc, match: 1'b0, err: 1'b0});
      wait_idle(n);
      chk("initen_value", {3'b0, value}, 8'h0F);
      chk("initen_overrun", {7'b0, overrun}, 8'd0);
      #1;

      // init at T+4 aborts the byte with no valid pulse.
      en = 1'b1; data = 8'hAA; last = 1'b1;
      tick();
      en = 1'b0; last = 1'b0;
      tick(); tick(); tick();
      init = 1'b1;
      tick();
      init = 1'b0; m_crc = 5'h1F;
      chk("abort_busy", {7'b0, busy}, 8'd0);
      chk("abort_value", {3'b0, value}, 8'h1F);
      nv = 0;
      repeat (12) begin
         @(negedge clk);
         if (valid === 1'b1) nv++;
      end
      chk("abort_no_valid", 8'(nv), 8'd0);
      #1;

      // Asynchronous reset at T+4 with overrun set.
      en = 1'b1; data = 8'hFF; last = 1'b1;
      tick();
      en = 1'b0; last = 1'b0;
      tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      chk("pre_rst_overrun", {7'b0, overrun}, 8'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_value", {3'b0, value}, 8'h1F);
      chk("arst_busy", {7'b0, busy}, 8'd0);
      chk("arst_overrun", {7'b0, overrun}, 8'd0);
      chk("arst_valid", {7'b0, valid}, 8'd0);
      tick();
      rst_n = 1'b1;
      m_crc = 5'h1F;
      tick();

      // Random multi-byte transfers checked through the scoreboard.
      check = 1'b1;
      for (int t = 0; t < 6; t++) begin
         do_init();
         for (int k = 0; k < 3; k++) begin
            b = 8'($urandom_range(0, 255));
            if (k == 2) begin
               f = crc5_byte(m_crc, b);
               recv = ($urandom_range(0, 1) == 1) ? f : (f ^ 5'(1 << $urandom_range(0, 4)));
            end
            strobe(b, k == 2);
            wait_idle(n);
            #1;
         end
      end
      check = 1'b0;
      tick(); tick();

      chk("sb_drained", 8'(sb_q.size()), 8'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
